// File: rtl/dma_pkg.sv
// Shared types and defaults for the AFU host-side DMA channel.
package dma_pkg;

  localparam int unsigned DEF_CL_SIZE_WIDTH = 512;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ISSUE = 2'd1,
    R_DRAIN = 2'd2,
    R_DONE  = 2'd3
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_RUN  = 2'd1,
    W_DONE = 2'd2
  } wr_state_t;

endpackage

// File: rtl/dma_host_channel_if.sv
// Host memory request/response port of the DMA channel (line reads and line writes).
interface dma_host_channel_if #(
  parameter int unsigned CL_ADDR_WIDTH = 26,
  parameter int unsigned CL_SIZE_WIDTH = dma_pkg::DEF_CL_SIZE_WIDTH
);
  logic                     host_rd_req_valid;
  logic                     host_rd_req_ready;
  logic [CL_ADDR_WIDTH-1:0] host_rd_req_addr;
  logic                     host_rd_rsp_valid;
  logic [CL_SIZE_WIDTH-1:0] host_rd_rsp_data;
  logic                     host_wr_req_valid;
  logic                     host_wr_req_ready;
  logic [CL_ADDR_WIDTH-1:0] host_wr_req_addr;
  logic [CL_SIZE_WIDTH-1:0] host_wr_req_data;

  modport master (
    output host_rd_req_valid, host_rd_req_addr,
    input  host_rd_req_ready,
    input  host_rd_rsp_valid, host_rd_rsp_data,
    output host_wr_req_valid, host_wr_req_addr, host_wr_req_data,
    input  host_wr_req_ready
  );

  modport slave (
    input  host_rd_req_valid, host_rd_req_addr,
    output host_rd_req_ready,
    output host_rd_rsp_valid, host_rd_rsp_data,
    input  host_wr_req_valid, host_wr_req_addr, host_wr_req_data,
    output host_wr_req_ready
  );
endinterface

// File: rtl/dma_line_fifo.sv
// Show-ahead line FIFO; push and pop may coincide, including when full.
module dma_line_fifo #(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head reads as zero when empty so the output is clean out of reset.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/dma_host_channel.sv
// Host-side DMA endpoint: credit-limited line reads into a FIFO, FIFO-fed line writes.
// Optional DMA_CHANNEL_STATS_EN adds saturating line and stall counters.
module dma_host_channel
  import dma_pkg::*;
#(
  parameter int unsigned CL_ADDR_WIDTH = 26,
  parameter int unsigned CL_SIZE_WIDTH = DEF_CL_SIZE_WIDTH,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CL_ADDR_WIDTH-1:0] rd_base,
  input  logic [CL_ADDR_WIDTH-1:0] wr_base,
  input  logic [CL_ADDR_WIDTH-1:0] rd_size,
  input  logic [CL_ADDR_WIDTH-1:0] wr_size,
  dma_host_channel_if.master       host,
  output logic                     empty,
  output logic [CL_SIZE_WIDTH-1:0] rd_data,
  input  logic                     rd_en,
  output logic                     full,
  input  logic [CL_SIZE_WIDTH-1:0] wr_data,
  input  logic                     wr_en,
  output logic                     rd_done,
  output logic                     wr_done,
  output logic                     err
`ifdef DMA_CHANNEL_STATS_EN
  ,
  output logic [31:0]              rd_line_cnt,
  output logic [31:0]              wr_line_cnt,
  output logic [31:0]              stall_cnt
`endif
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  rd_state_t rd_state;
  wr_state_t wr_state;

  logic [CL_ADDR_WIDTH-1:0] rd_base_q, rd_size_q, rd_issued;
  logic [CL_ADDR_WIDTH-1:0] wr_base_q, wr_size_q, wr_count;
  logic [CW-1:0]            credits;
  logic [CW-1:0]            outstanding;
  logic [CL_SIZE_WIDTH-1:0] wr_head;
  logic rd_full, wr_empty;
  logic busy, start_ok;
  logic rd_issue, rd_pop, rsp_ok, rsp_bad;
  logic wr_push, wr_pop;

  assign busy     = (rd_state == R_ISSUE) || (rd_state == R_DRAIN) || (wr_state == W_RUN);
  assign start_ok = start && !busy;

  assign host.host_rd_req_valid = (rd_state == R_ISSUE) && (credits != '0);
  assign host.host_rd_req_addr  = rd_base_q + rd_issued;
  assign rd_issue = host.host_rd_req_valid && host.host_rd_req_ready;
  assign rd_pop   = rd_en && !empty;
  // The full guard is unreachable under credit flow control but keeps the FIFO safe.
  assign rsp_ok   = host.host_rd_rsp_valid && (outstanding != '0) && (!rd_full || rd_pop);
  assign rsp_bad  = host.host_rd_rsp_valid && !rsp_ok;

  assign host.host_wr_req_valid = (wr_state == W_RUN) && !wr_empty;
  assign host.host_wr_req_addr  = wr_base_q + wr_count;
  assign host.host_wr_req_data  = wr_head;
  assign wr_pop  = host.host_wr_req_valid && host.host_wr_req_ready;
  assign wr_push = wr_en && !full;

  dma_line_fifo #(.WIDTH(CL_SIZE_WIDTH), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_ok),
    .push_data (host.host_rd_rsp_data),
    .pop       (rd_pop),
    .head      (rd_data),
    .empty     (empty),
    .full      (rd_full)
  );

  dma_line_fifo #(.WIDTH(CL_SIZE_WIDTH), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_push),
    .push_data (wr_data),
    .pop       (wr_pop),
    .head      (wr_head),
    .empty     (wr_empty),
    .full      (full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state    <= R_IDLE;
      rd_base_q   <= '0;
      rd_size_q   <= '0;
      rd_issued   <= '0;
      rd_done     <= 1'b0;
      credits     <= DEPTH_CNT;
      outstanding <= '0;
    end else begin
      credits     <= credits - CW'(rd_issue) + CW'(rd_pop);
      outstanding <= outstanding + CW'(rd_issue) - CW'(rsp_ok);
      case (rd_state)
        R_ISSUE: begin
          if (rd_issue) begin
            rd_issued <= rd_issued + 1'b1;
            if (rd_issued + 1'b1 == rd_size_q) rd_state <= R_DRAIN;
          end
        end
        R_DRAIN: begin
          if (rsp_ok && (outstanding == CW'(1))) begin
            rd_state <= R_DONE;
            rd_done  <= 1'b1;
          end
        end
        default: begin
          if (start_ok) begin
            rd_base_q <= rd_base;
            rd_size_q <= rd_size;
            rd_issued <= '0;
            rd_done   <= (rd_size == '0);
            rd_state  <= (rd_size == '0) ? R_DONE : R_ISSUE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state  <= W_IDLE;
      wr_base_q <= '0;
      wr_size_q <= '0;
      wr_count  <= '0;
      wr_done   <= 1'b0;
    end else begin
      case (wr_state)
        W_RUN: begin
          if (wr_pop) begin
            wr_count <= wr_count + 1'b1;
            if (wr_count + 1'b1 == wr_size_q) begin
              wr_state <= W_DONE;
              wr_done  <= 1'b1;
            end
          end
        end
        default: begin
          if (start_ok) begin
            wr_base_q <= wr_base;
            wr_size_q <= wr_size;
            wr_count  <= '0;
            wr_done   <= (wr_size == '0);
            wr_state  <= (wr_size == '0) ? W_DONE : W_RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if ((rd_en && empty) || (wr_en && full) || rsp_bad) err <= 1'b1;
  end

`ifdef DMA_CHANNEL_STATS_EN
  logic stall;
  assign stall = (host.host_rd_req_valid && !host.host_rd_req_ready) ||
                 (host.host_wr_req_valid && !host.host_wr_req_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_line_cnt <= '0;
      wr_line_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (rsp_ok && (rd_line_cnt != '1)) rd_line_cnt <= rd_line_cnt + 32'd1;
      if (wr_pop && (wr_line_cnt != '1)) wr_line_cnt <= wr_line_cnt + 32'd1;
      if (stall  && (stall_cnt   != '1)) stall_cnt   <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dma_host_channel.sv
// Scoreboard bench for dma_host_channel: directed runs with a 2-cycle-latency host model.
module tb_dma_host_channel;
  localparam int unsigned AW    = 26;
  localparam int unsigned DW    = 512;
  localparam int unsigned DEPTH = 4;

  typedef struct { int due; logic [AW-1:0] addr; } pend_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wexp_t;

  logic clk = 1'b0;
  logic rst, start, rd_en, wr_en;
  logic [AW-1:0] rd_base, wr_base, rd_size, wr_size;
  logic [DW-1:0] rd_data, wr_data;
  logic empty, full, rd_done, wr_done, err;
`ifdef DMA_CHANNEL_STATS_EN
  logic [31:0] rd_line_cnt, wr_line_cnt, stall_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rd_req_cnt = 0;

  pend_t         pend[$];
  logic [AW-1:0] exp_rd_addr_q[$];
  logic [DW-1:0] exp_rd_line_q[$];
  wexp_t         exp_wr_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dma_host_channel_if #(.CL_ADDR_WIDTH(AW), .CL_SIZE_WIDTH(DW)) bus ();

  dma_host_channel #(.CL_ADDR_WIDTH(AW), .CL_SIZE_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rd_base (rd_base),
    .wr_base (wr_base),
    .rd_size (rd_size),
    .wr_size (wr_size),
    .host    (bus),
    .empty   (empty),
    .rd_data (rd_data),
    .rd_en   (rd_en),
    .full    (full),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .rd_done (rd_done),
    .wr_done (wr_done),
    .err     (err)
`ifdef DMA_CHANNEL_STATS_EN
    ,
    .rd_line_cnt (rd_line_cnt),
    .wr_line_cnt (wr_line_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  function automatic logic [DW-1:0] rline(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = {a, i[5:0]};
    return d;
  endfunction

  function automatic logic [DW-1:0] wline(input int k);
    logic [DW-1:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = 32'hC0DE_0000 + 32'(k * 16 + i);
    return d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every handshake/pop against the scoreboard queues.
  initial begin
    wexp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.host_rd_req_valid && bus.host_rd_req_ready) begin
          rd_req_cnt++;
          pend.push_back('{due: cyc + 3, addr: bus.host_rd_req_addr});
          if (exp_rd_addr_q.size() == 0) check("rd_req_unexpected", exp_rd_addr_q.size(), 1);
          else check("rd_req_addr", bus.host_rd_req_addr, exp_rd_addr_q.pop_front());
        end
        if (rd_en && !empty) begin
          if (exp_rd_line_q.size() == 0) check("rd_pop_unexpected", exp_rd_line_q.size(), 1);
          else check_line("rd_data", rd_data, exp_rd_line_q.pop_front());
        end
        if (bus.host_wr_req_valid && bus.host_wr_req_ready) begin
          if (exp_wr_q.size() == 0) check("wr_req_unexpected", exp_wr_q.size(), 1);
          else begin
            e = exp_wr_q.pop_front();
            check("wr_req_addr", bus.host_wr_req_addr, e.addr);
            check_line("wr_req_data", bus.host_wr_req_data, e.data);
          end
        end
      end
    end
  end

  // Host model: in-order responses two cycles after each accepted request.
  initial begin
    bus.host_rd_rsp_valid = 1'b0;
    bus.host_rd_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      if (pend.size() != 0 && pend[0].due <= cyc + 1) begin
        bus.host_rd_rsp_valid = 1'b1;
        bus.host_rd_rsp_data  = rline(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        bus.host_rd_rsp_valid = 1'b0;
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; rd_en = 1'b0; wr_en = 1'b0; wr_data = '0;
    rd_base = '0; wr_base = '0; rd_size = '0; wr_size = '0;
    pend.delete(); exp_rd_addr_q.delete(); exp_rd_line_q.delete(); exp_wr_q.delete();
    step(2);
    rst = 1'b0;
    rd_req_cnt = 0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic expect_reads(input logic [AW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_rd_addr_q.push_back(base + AW'(i));
      exp_rd_line_q.push_back(rline(base + AW'(i)));
    end
  endtask

  task automatic pop_lines(input int n);
    int got = 0;
    int guard = 0;
    while (got < n && guard < 200) begin
      rd_en = !empty;
      if (!empty) got++;
      step(1);
      guard++;
    end
    rd_en = 1'b0;
    check("pop_count", got, n);
  endtask

  task automatic push_wline(input int k);
    wr_en = 1'b1; wr_data = wline(k);
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic wait_rd_done;
    for (int i = 0; i < 200 && !rd_done; i++) step(1);
    check("rd_done", rd_done, 1);
  endtask

  task automatic wait_wr_done;
    for (int i = 0; i < 200 && !wr_done; i++) step(1);
    check("wr_done", wr_done, 1);
  endtask

  initial begin
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_data;
    bus.host_rd_req_ready = 1'b1;
    bus.host_wr_req_ready = 1'b1;
    do_reset();

    check("rst_rd_valid", bus.host_rd_req_valid, 0);
    check("rst_wr_valid", bus.host_wr_req_valid, 0);
    check("rst_rd_addr", bus.host_rd_req_addr, 0);
    check("rst_wr_addr", bus.host_wr_req_addr, 0);
    check_line("rst_wr_data", bus.host_wr_req_data, '0);
    check_line("rst_rd_data", rd_data, '0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_flags", {rd_done, wr_done, err}, 3'b000);

    // Three-line read from 0x100.
    rd_base = 26'h100; rd_size = 26'd3;
    expect_reads(26'h100, 3);
    pulse_start();
    check("first_rd_valid", bus.host_rd_req_valid, 1);
    check("first_rd_addr", bus.host_rd_req_addr, 26'h100);
    wait_rd_done();
    pop_lines(3);
    check("rd_empty_after", empty, 1);
    check("rd_err_clean", err, 0);
    check("rd_req_total", rd_req_cnt, 3);
    check("rd_scoreboard_drained", exp_rd_line_q.size(), 0);

    // Credit limit: no pops lets exactly FIFO_DEPTH requests through.
    do_reset();
    rd_base = 26'h300; rd_size = 26'd8;
    expect_reads(26'h300, 8);
    pulse_start();
    step(20);
    check("credit_limit", rd_req_cnt, DEPTH);
    check("credit_full_valid", bus.host_rd_req_valid, 0);
    pop_lines(1);
    step(20);
    check("credit_after_pop", rd_req_cnt, DEPTH + 1);

    // Write wraps past the top of the address space, with a 5-cycle stall.
    do_reset();
    bus.host_wr_req_ready = 1'b0;
    push_wline(0);
    push_wline(1);
    exp_wr_q.push_back('{addr: 26'h3FF_FFFF, data: wline(0)});
    exp_wr_q.push_back('{addr: 26'h000_0000, data: wline(1)});
    check("wr_idle_no_valid", bus.host_wr_req_valid, 0);
    wr_base = 26'h3FF_FFFF; wr_size = 26'd2;
    pulse_start();
    check("wr_valid_on_start", bus.host_wr_req_valid, 1);
    check("wr_first_addr", bus.host_wr_req_addr, 26'h3FF_FFFF);
    h_addr = bus.host_wr_req_addr;
    h_data = bus.host_wr_req_data;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("stall_valid_held", bus.host_wr_req_valid, 1);
      check("stall_addr_held", bus.host_wr_req_addr, h_addr);
      check_line("stall_data_held", bus.host_wr_req_data, h_data);
    end
`ifdef DMA_CHANNEL_STATS_EN
    check("stall_cnt", stall_cnt, 5);
`endif
    bus.host_wr_req_ready = 1'b1;
    wait_wr_done();
    check("wr_scoreboard_drained", exp_wr_q.size(), 0);
`ifdef DMA_CHANNEL_STATS_EN
    check("wr_line_cnt", wr_line_cnt, 2);
`endif

    // Underflow: pop while empty.
    do_reset();
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    check("underflow_err", err, 1);
    check("underflow_empty", empty, 1);

    // Overflow: fifth push into a full write FIFO is dropped.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push_wline(k);
      exp_wr_q.push_back('{addr: 26'h50 + AW'(k), data: wline(k)});
    end
    check("wr_fifo_full", full, 1);
    check("no_err_before_overflow", err, 0);
    push_wline(9);
    check("overflow_err", err, 1);
    check("overflow_still_full", full, 1);
    wr_base = 26'h50; wr_size = 26'd4;
    pulse_start();
    wait_wr_done();
    check("overflow_drop_drained", exp_wr_q.size(), 0);
    check("wr_fifo_not_full", full, 0);

    // Reset during R_ISSUE, clean single-line run, then a stale response.
    do_reset();
    rd_base = 26'h200; rd_size = 26'd8;
    expect_reads(26'h200, 8);
    pulse_start();
    step(1);
    do_reset();
    rd_base = 26'h400; rd_size = 26'd1;
    expect_reads(26'h400, 1);
    pulse_start();
    wait_rd_done();
    pop_lines(1);
    check("post_reset_req_cnt", rd_req_cnt, 1);
    check("post_reset_no_err", err, 0);
    pend.push_back('{due: cyc + 1, addr: 26'h777});
    step(3);
    check("stale_rsp_err", err, 1);
    check("stale_rsp_dropped", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
